// File: rtl/lcd_ctrl_param_pkg.sv
// Shared types for the parametrised LCD image controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lcd_ctrl_pkg;

  localparam int CMD_W = 4;

  // Command codes carried on cmd when cmd_valid is high.
  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE    = 4'd0,
    CMD_UP       = 4'd1,
    CMD_DOWN     = 4'd2,
    CMD_LEFT     = 4'd3,
    CMD_RIGHT    = 4'd4,
    CMD_MAX      = 4'd5,
    CMD_MIN      = 4'd6,
    CMD_AVG      = 4'd7,
    CMD_ROT_CCW  = 4'd8,
    CMD_ROT_CW   = 4'd9,
    CMD_MIR_X    = 4'd10,
    CMD_MIR_Y    = 4'd11,
    CMD_RECENTRE = 4'd12,
    CMD_NOP13    = 4'd13,
    CMD_NOP14    = 4'd14,
    CMD_NOP15    = 4'd15
  } cmd_e;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lcd_ctrl_param_if.sv
// Bus bundle between the LCD controller, its host and the IROM/IRB memories.
// Latency: n/a (wires only).
// Backpressure: busy gates command acceptance; no queuing.
// Ports: cmd/cmd_valid (host -> ctrl), IROM_Q (IROM -> ctrl),
//        IROM_EN/IROM_A, IRB_RW/IRB_D/IRB_A, busy/done (ctrl -> outside).
interface lcd_ctrl_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  import lcd_ctrl_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_valid;
  logic [DATA_W-1:0] IROM_Q;
  logic              IROM_EN;
  logic [ADDR_W-1:0] IROM_A;
  logic              IRB_RW;
  logic [DATA_W-1:0] IRB_D;
  logic [ADDR_W-1:0] IRB_A;
  logic              busy;
  logic              done;

  // Host / memory side.
  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );

  // Controller side.
  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );

endinterface

// File: rtl/lcd_ctrl_param_blk_alu.sv
// 2x2 block operator: Max, Min, Average, rotations, mirrors, else passthrough.
// Latency: combinational.
// Backpressure: none.
// Ports: i_op (command), i_tl/i_tr/i_bl/i_br (current block),
//        o_tl/o_tr/o_bl/o_br (block after the operation).
module lcd_blk_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  cmd_e              i_op,
  input  logic [DATA_W-1:0] i_tl,
  input  logic [DATA_W-1:0] i_tr,
  input  logic [DATA_W-1:0] i_bl,
  input  logic [DATA_W-1:0] i_br,
  output logic [DATA_W-1:0] o_tl,
  output logic [DATA_W-1:0] o_tr,
  output logic [DATA_W-1:0] o_bl,
  output logic [DATA_W-1:0] o_br
);

  logic [DATA_W-1:0] w_max_t, w_max_b, w_max;
  logic [DATA_W-1:0] w_min_t, w_min_b, w_min;
  logic [DATA_W+1:0] w_sum;
  logic [DATA_W-1:0] w_avg;

  assign w_max_t = (i_tl > i_tr) ? i_tl : i_tr;
  assign w_max_b = (i_bl > i_br) ? i_bl : i_br;
  assign w_max   = (w_max_t > w_max_b) ? w_max_t : w_max_b;
  assign w_min_t = (i_tl < i_tr) ? i_tl : i_tr;
  assign w_min_b = (i_bl < i_br) ? i_bl : i_br;
  assign w_min   = (w_min_t < w_min_b) ? w_min_t : w_min_b;

  // Two extra bits hold the four-way sum without overflow; floor divide by 4.
  assign w_sum = {2'b00, i_tl} + {2'b00, i_tr} + {2'b00, i_bl} + {2'b00, i_br};
  assign w_avg = w_sum[DATA_W+1:2];

  always_comb begin
    o_tl = i_tl;
    o_tr = i_tr;
    o_bl = i_bl;
    o_br = i_br;
    case (i_op)
      CMD_MAX: begin
        o_tl = w_max; o_tr = w_max; o_bl = w_max; o_br = w_max;
      end
      CMD_MIN: begin
        o_tl = w_min; o_tr = w_min; o_bl = w_min; o_br = w_min;
      end
      CMD_AVG: begin
        o_tl = w_avg; o_tr = w_avg; o_bl = w_avg; o_br = w_avg;
      end
      CMD_ROT_CCW: begin
        o_tl = i_tr; o_tr = i_br; o_br = i_bl; o_bl = i_tl;
      end
      CMD_ROT_CW: begin
        o_tl = i_bl; o_tr = i_tl; o_br = i_tr; o_bl = i_br;
      end
      CMD_MIR_X: begin
        o_tl = i_bl; o_bl = i_tl; o_tr = i_br; o_br = i_tr;
      end
      CMD_MIR_Y: begin
        o_tl = i_tr; o_tr = i_tl; o_bl = i_br; o_br = i_bl;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads IROM into a pixel buffer, runs 2x2 block
// commands, dumps the buffer to IRB on Write.
// Latency: load N+1 cycles; non-write command 1 cycle; Write N cycles + 1 done cycle.
// Backpressure: busy=1 means cmd_valid is ignored (no queuing).
// Ports: clk, reset (async, active high), bus (slave modport of lcd_ctrl_param_if).
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  lcd_ctrl_param_if.slave bus
);

  localparam int N      = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(N);
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);

  state_e            r_state, w_state_nxt;
  logic              r_irom_en, w_irom_en_nxt;
  logic [ADDR_W-1:0] r_irom_a, w_irom_a_nxt;
  logic              r_irb_rw, w_irb_rw_nxt;
  logic [DATA_W-1:0] r_irb_d, w_irb_d_nxt;
  logic [ADDR_W-1:0] r_irb_a, w_irb_a_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [XW-1:0]     r_px, w_px_nxt;
  logic [YW-1:0]     r_py, w_py_nxt;
  cmd_e              r_cmd, w_cmd_nxt;

  logic [DATA_W-1:0] r_pix [N];

  logic              w_load_wr;
  logic              w_exec_wr;
  logic [ADDR_W-1:0] w_irb_a_inc;
  logic [XW-1:0]     w_x0;
  logic [YW-1:0]     w_y0;
  logic [ADDR_W-1:0] w_a_tl, w_a_tr, w_a_bl, w_a_br;
  logic [DATA_W-1:0] w_new_tl, w_new_tr, w_new_bl, w_new_br;

  // Power-of-two geometry: pixel index y*IMG_W+x is just {y, x}.
  assign w_x0   = r_px - XW'(1);
  assign w_y0   = r_py - YW'(1);
  assign w_a_tl = {w_y0, w_x0};
  assign w_a_tr = {w_y0, r_px};
  assign w_a_bl = {r_py, w_x0};
  assign w_a_br = {r_py, r_px};

  assign w_irb_a_inc = r_irb_a + ADDR_W'(1);

  lcd_blk_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op (r_cmd),
    .i_tl (r_pix[w_a_tl]),
    .i_tr (r_pix[w_a_tr]),
    .i_bl (r_pix[w_a_bl]),
    .i_br (r_pix[w_a_br]),
    .o_tl (w_new_tl),
    .o_tr (w_new_tr),
    .o_bl (w_new_bl),
    .o_br (w_new_br)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_LOAD;
      r_irom_en <= 1'b1;
      r_irom_a  <= '0;
      r_irb_rw  <= 1'b1;
      r_irb_d   <= '0;
      r_irb_a   <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_px      <= XW'(IMG_W / 2);
      r_py      <= YW'(IMG_H / 2);
      r_cmd     <= CMD_WRITE;
    end else begin
      r_state   <= w_state_nxt;
      r_irom_en <= w_irom_en_nxt;
      r_irom_a  <= w_irom_a_nxt;
      r_irb_rw  <= w_irb_rw_nxt;
      r_irb_d   <= w_irb_d_nxt;
      r_irb_a   <= w_irb_a_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_px      <= w_px_nxt;
      r_py      <= w_py_nxt;
      r_cmd     <= w_cmd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_irom_en_nxt = r_irom_en;
    w_irom_a_nxt  = r_irom_a;
    w_irb_rw_nxt  = r_irb_rw;
    w_irb_d_nxt   = r_irb_d;
    w_irb_a_nxt   = r_irb_a;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_px_nxt      = r_px;
    w_py_nxt      = r_py;
    w_cmd_nxt     = r_cmd;
    w_load_wr     = 1'b0;
    w_exec_wr     = 1'b0;

    case (r_state)
      ST_LOAD: begin
        // IROM_EN still high means the read burst has not started yet.
        if (r_irom_en) begin
          w_irom_en_nxt = 1'b0;
          w_irom_a_nxt  = '0;
        end else begin
          w_load_wr = 1'b1;
          if (r_irom_a == ADDR_W'(N - 1)) begin
            w_irom_en_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_irom_a_nxt = r_irom_a + ADDR_W'(1);
          end
        end
      end

      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_busy_nxt = 1'b1;
          w_cmd_nxt  = cmd_e'(bus.cmd);
          if (cmd_e'(bus.cmd) == CMD_WRITE) begin
            w_state_nxt  = ST_WRITE;
            w_irb_rw_nxt = 1'b0;
            w_irb_a_nxt  = '0;
            w_irb_d_nxt  = r_pix[0];
          end else begin
            w_state_nxt = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        // Block ops and moves both use the pre-move point this cycle.
        w_exec_wr   = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
        case (r_cmd)
          CMD_UP:    if (r_py != YW'(1))         w_py_nxt = r_py - YW'(1);
          CMD_DOWN:  if (r_py != YW'(IMG_H - 1)) w_py_nxt = r_py + YW'(1);
          CMD_LEFT:  if (r_px != XW'(1))         w_px_nxt = r_px - XW'(1);
          CMD_RIGHT: if (r_px != XW'(IMG_W - 1)) w_px_nxt = r_px + XW'(1);
          CMD_RECENTRE: begin
            w_px_nxt = XW'(IMG_W / 2);
            w_py_nxt = YW'(IMG_H / 2);
          end
          default: ;
        endcase
      end

      ST_WRITE: begin
        if (r_irb_a == ADDR_W'(N - 1)) begin
          w_irb_rw_nxt = 1'b1;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_irb_a_nxt = w_irb_a_inc;
          w_irb_d_nxt = r_pix[w_irb_a_inc];
        end
      end

      ST_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Buffer contents are fully rewritten by every LOAD, so no reset is needed.
  // Non-ALU commands write the block back unchanged (ALU passthrough).
  always_ff @(posedge clk) begin
    if (w_load_wr) begin
      r_pix[r_irom_a] <= bus.IROM_Q;
    end
    if (w_exec_wr) begin
      r_pix[w_a_tl] <= w_new_tl;
      r_pix[w_a_tr] <= w_new_tr;
      r_pix[w_a_bl] <= w_new_bl;
      r_pix[w_a_br] <= w_new_br;
    end
  end

  assign bus.IROM_EN = r_irom_en;
  assign bus.IROM_A  = r_irom_a;
  assign bus.IRB_RW  = r_irb_rw;
  assign bus.IRB_D   = r_irb_d;
  assign bus.IRB_A   = r_irb_a;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param at default geometry (8x8, 8-bit pixels, IROM[k]=k).
module tb_lcd_ctrl_param;
  import lcd_ctrl_pkg::*;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int DATA_W = 8;
  localparam int N      = IMG_W * IMG_H;
  localparam int ADDR_W = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_ctrl_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  lcd_ctrl_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] rom     [N];
  logic [DATA_W-1:0] irb     [N];
  logic [DATA_W-1:0] exp_img [N];
  int mpx, mpy;
  int rd_idx = 0;
  int wr_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // IROM: data for the address driven this cycle is ready before the next edge.
  always @(negedge clk) begin
    if (!bus.IROM_EN) bus.IROM_Q = rom[bus.IROM_A];
  end

  // Per-cycle compare against the model; also records the IRB memory.
  always @(negedge clk) begin
    if (reset) begin
      rd_idx = 0;
      wr_idx = 0;
    end else begin
      if (!bus.IROM_EN) begin
        chk("irom_addr_seq", bus.IROM_A, rd_idx);
        rd_idx++;
      end
      if (!bus.IRB_RW) begin
        chk("irb_addr_seq", bus.IRB_A, wr_idx);
        if (wr_idx < N) chk("irb_data", bus.IRB_D, exp_img[wr_idx]);
        irb[bus.IRB_A] = bus.IRB_D;
        wr_idx++;
      end else begin
        if (bus.done) chk("done_after_n_writes", wr_idx, N);
        wr_idx = 0;
      end
    end
  end

  // Specification-level model of one command on the image and point.
  task automatic model_cmd(input int c);
    int tl, tr, bl, br, s;
    logic [DATA_W-1:0] a, b, cc, d, m;
    tl = (mpy - 1) * IMG_W + (mpx - 1);
    tr = tl + 1;
    bl = tl + IMG_W;
    br = bl + 1;
    a = exp_img[tl]; b = exp_img[tr]; cc = exp_img[bl]; d = exp_img[br];
    case (c)
      1: if (mpy > 1) mpy--;
      2: if (mpy < IMG_H - 1) mpy++;
      3: if (mpx > 1) mpx--;
      4: if (mpx < IMG_W - 1) mpx++;
      5, 6: begin
        m = a;
        if (c == 5) begin
          if (b > m) m = b;
          if (cc > m) m = cc;
          if (d > m) m = d;
        end else begin
          if (b < m) m = b;
          if (cc < m) m = cc;
          if (d < m) m = d;
        end
        exp_img[tl] = m; exp_img[tr] = m; exp_img[bl] = m; exp_img[br] = m;
      end
      7: begin
        s = int'(a) + int'(b) + int'(cc) + int'(d);
        m = DATA_W'(s / 4);
        exp_img[tl] = m; exp_img[tr] = m; exp_img[bl] = m; exp_img[br] = m;
      end
      8:  begin exp_img[tl] = b;  exp_img[tr] = d; exp_img[br] = cc; exp_img[bl] = a; end
      9:  begin exp_img[tl] = cc; exp_img[tr] = a; exp_img[br] = b;  exp_img[bl] = d; end
      10: begin exp_img[tl] = cc; exp_img[bl] = a; exp_img[tr] = d;  exp_img[br] = b; end
      11: begin exp_img[tl] = b;  exp_img[tr] = a; exp_img[bl] = d;  exp_img[br] = cc; end
      12: begin mpx = IMG_W / 2; mpy = IMG_H / 2; end
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < N + 10) begin
      @(negedge clk);
      n++;
    end
    chk("write_done_seen", bus.done, 1);
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
  endtask

  task automatic send_cmd(input int c);
    wait_idle();
    bus.cmd       = CMD_W'(c);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    if (c == 0) begin
      wait_done();
    end else begin
      model_cmd(c);
      @(negedge clk);
      chk("busy_exec_one_cycle", bus.busy, 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_irom_en"}, bus.IROM_EN, 1);
    chk({tag, "_irom_a"},  bus.IROM_A, 0);
    chk({tag, "_irb_rw"},  bus.IRB_RW, 1);
    chk({tag, "_irb_d"},   bus.IRB_D, 0);
    chk({tag, "_irb_a"},   bus.IRB_A, 0);
    chk({tag, "_busy"},    bus.busy, 1);
    chk({tag, "_done"},    bus.done, 0);
  endtask

  task automatic do_reset();
    int cnt = 0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst");
    for (int k = 0; k < N; k++) exp_img[k] = rom[k];
    mpx = IMG_W / 2;
    mpy = IMG_H / 2;
    reset = 1'b0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        chk("load_first_en", bus.IROM_EN, 0);
        chk("load_first_a", bus.IROM_A, 0);
      end
    end
    chk("load_busy_cycles", cnt, N + 1);
    chk("load_irom_en_off", bus.IROM_EN, 1);
  endtask

  task automatic clear_irb();
    for (int k = 0; k < N; k++) irb[k] = 8'hEE;
  endtask

  task automatic dump_check(input string tag);
    int bad = 0;
    for (int k = 0; k < N; k++) if (irb[k] !== exp_img[k]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < N; k++) rom[k] = DATA_W'(k);
    bus.cmd       = '0;
    bus.cmd_valid = 1'b0;
    bus.IROM_Q    = '0;
    repeat (2) @(negedge clk);

    // Plain load and dump.
    do_reset();
    clear_irb();
    send_cmd(0);
    dump_check("t1_image");
    chk("t1_irb0", irb[0], 0);
    chk("t1_irb63", irb[63], 63);

    // Average at centre: (27+28+35+36)/4 = 31.
    do_reset();
    clear_irb();
    send_cmd(7);
    send_cmd(0);
    dump_check("t2_image");
    chk("t2_irb27", irb[27], 31);
    chk("t2_irb28", irb[28], 31);
    chk("t2_irb35", irb[35], 31);
    chk("t2_irb36", irb[36], 31);
    chk("t2_irb26", irb[26], 26);

    // Left x5 saturates at px=1, then Max over 24,25,32,33.
    do_reset();
    clear_irb();
    repeat (5) send_cmd(3);
    send_cmd(5);
    send_cmd(0);
    dump_check("t3_image");
    chk("t3_irb24", irb[24], 33);
    chk("t3_irb25", irb[25], 33);
    chk("t3_irb32", irb[32], 33);
    chk("t3_irb23", irb[23], 23);
    chk("t3_irb31", irb[31], 31);
    chk("t3_irb39", irb[39], 39);

    // Rotate CW at centre.
    do_reset();
    clear_irb();
    send_cmd(9);
    send_cmd(0);
    dump_check("t4_image");
    chk("t4_irb27", irb[27], 35);
    chk("t4_irb28", irb[28], 27);
    chk("t4_irb36", irb[36], 28);
    chk("t4_irb35", irb[35], 36);

    // Mirror X, dump, then Recentre + Min, dump again.
    do_reset();
    clear_irb();
    send_cmd(10);
    send_cmd(0);
    dump_check("t5a_image");
    chk("t5a_irb27", irb[27], 35);
    chk("t5a_irb35", irb[35], 27);
    chk("t5a_irb28", irb[28], 36);
    chk("t5a_irb36", irb[36], 28);
    clear_irb();
    send_cmd(12);
    send_cmd(6);
    send_cmd(0);
    dump_check("t5b_image");
    chk("t5b_irb27", irb[27], 27);
    chk("t5b_irb28", irb[28], 27);
    chk("t5b_irb35", irb[35], 27);
    chk("t5b_irb36", irb[36], 27);

    // Protocol: NOP, command during EXEC busy, commands during WRITE.
    do_reset();
    send_cmd(13);
    wait_idle();
    bus.cmd       = CMD_W'(4);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    chk("p_busy_right", bus.busy, 1);
    bus.cmd = CMD_W'(2);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    model_cmd(4);
    chk("p_busy_after_right", bus.busy, 0);
    send_cmd(5);
    clear_irb();
    send_cmd(0);
    dump_check("p1_image");
    chk("p1_irb28", irb[28], 37);
    chk("p1_irb44", irb[44], 44);

    wait_idle();
    clear_irb();
    bus.cmd       = CMD_W'(0);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd = CMD_W'(7);
    repeat (5) @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_done();
    dump_check("p2_image");
    clear_irb();
    send_cmd(0);
    dump_check("p3_image_unchanged");

    // Reset on write cycle 30, then full reload and dump.
    clear_irb();
    wait_idle();
    bus.cmd       = CMD_W'(0);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.IRB_A != ADDR_W'(30) && n < N + 10) begin
      @(negedge clk);
      n++;
    end
    chk("p4_reached_cycle30", bus.IRB_A, 30);
    reset = 1'b1;
    #1;
    check_reset_vals("midwr");
    do_reset();
    chk("p4_partial_20", irb[20], 20);
    chk("p4_partial_31", irb[31], 8'hEE);
    chk("p4_partial_63", irb[63], 8'hEE);
    clear_irb();
    send_cmd(0);
    dump_check("p4_image_after_reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
